// File: rtl/pid_math.sv
// PID term datapath: saturated error, P term, delayed-difference D term and an
// optional saturating integrator (built only when PID_ITERM_EN is defined).
module pid_math #(
  parameter int ERR_W   = 10,
  parameter int D_DEPTH = 12,
  parameter int DDIFF_W = 7,
  parameter int D_GAIN  = 7,
  parameter int I_ACC_W = 18,
  parameter int I_SHIFT = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               vld,
  input  logic signed [15:0]                 desired,
  input  logic signed [15:0]                 actual,
  input  logic                               frz,
  input  logic                               clr_i,
  output logic signed [ERR_W-1:0]            pterm,
  output logic signed [DDIFF_W+4:0]          dterm,
  output logic signed [I_ACC_W-I_SHIFT-1:0]  iterm,
  output logic                               out_vld
);

  localparam int DW    = ERR_W + 1;
  localparam int PW    = DDIFF_W + 5;
  localparam int CNT_W = $clog2(D_DEPTH + 1);

  localparam logic signed [16:0]      ERR_MAX  = 17'((1 <<< (ERR_W - 1)) - 1);
  localparam logic signed [16:0]      ERR_MIN  = 17'(-(1 <<< (ERR_W - 1)));
  localparam logic signed [DW-1:0]    DD_MAX   = DW'((1 <<< (DDIFF_W - 1)) - 1);
  localparam logic signed [DW-1:0]    DD_MIN   = DW'(-(1 <<< (DDIFF_W - 1)));
  localparam logic signed [PW-1:0]    GAIN_EXT = PW'(D_GAIN & 31);
  localparam logic        [CNT_W-1:0] FULL     = CNT_W'(D_DEPTH);

  logic signed [16:0]        diff;
  logic signed [ERR_W-1:0]   err_sat;
  logic signed [ERR_W-1:0]   p_next;
  logic signed [ERR_W-1:0]   q [D_DEPTH];
  logic signed [DW-1:0]      dd;
  logic signed [DDIFF_W-1:0] dd_sat;
  logic signed [PW-1:0]      dd_ext;
  logic signed [PW-1:0]      d_next;
  logic        [CNT_W-1:0]   fill_cnt;

  assign diff = {actual[15], actual} - {desired[15], desired};

  always_comb begin
    err_sat = diff[ERR_W-1:0];
    if (diff > ERR_MAX)
      err_sat = ERR_MAX[ERR_W-1:0];
    else if (diff < ERR_MIN)
      err_sat = ERR_MIN[ERR_W-1:0];
  end

  assign p_next = (err_sat >>> 1) + (err_sat >>> 3);

  // Difference against the oldest queued sample, taken before this strobe shifts it out
  assign dd = {err_sat[ERR_W-1], err_sat} - {q[D_DEPTH-1][ERR_W-1], q[D_DEPTH-1]};

  always_comb begin
    dd_sat = dd[DDIFF_W-1:0];
    if (dd > DD_MAX)
      dd_sat = DD_MAX[DDIFF_W-1:0];
    else if (dd < DD_MIN)
      dd_sat = DD_MIN[DDIFF_W-1:0];
  end

  assign dd_ext = {{5{dd_sat[DDIFF_W-1]}}, dd_sat};
  assign d_next = (fill_cnt < FULL) ? '0 : dd_ext * GAIN_EXT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D_DEPTH; i++)
        q[i] <= '0;
      fill_cnt <= '0;
    end else if (vld) begin
      q[0] <= err_sat;
      for (int i = 1; i < D_DEPTH; i++)
        q[i] <= q[i-1];
      if (fill_cnt != FULL)
        fill_cnt <= fill_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pterm   <= '0;
      dterm   <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= vld;
      if (vld) begin
        pterm <= p_next;
        dterm <= d_next;
      end
    end
  end

`ifdef PID_ITERM_EN
  logic signed [I_ACC_W-1:0] acc;
  logic signed [I_ACC_W-1:0] acc_next;
  logic signed [I_ACC_W:0]   sum;

  assign sum = {acc[I_ACC_W-1], acc}
             + {{(I_ACC_W + 1 - ERR_W){err_sat[ERR_W-1]}}, err_sat};

  // Overflow shows as disagreement between the two top bits of the widened sum
  always_comb begin
    acc_next = acc;
    if (clr_i)
      acc_next = '0;
    else if (vld && !frz) begin
      if (sum[I_ACC_W] != sum[I_ACC_W-1])
        acc_next = sum[I_ACC_W] ? {1'b1, {(I_ACC_W-1){1'b0}}}
                                : {1'b0, {(I_ACC_W-1){1'b1}}};
      else
        acc_next = sum[I_ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      iterm <= '0;
    end else begin
      acc <= acc_next;
      if (vld)
        iterm <= acc_next[I_ACC_W-1:I_SHIFT];
    end
  end
`else
  logic unused_ctrl;

  assign unused_ctrl = frz ^ clr_i;
  assign iterm       = '0;
`endif

endmodule

// File: tb/tb_pid_math.sv
// Randomized and directed check of pid_math against an arithmetic reference
// model built from the error history and an integer accumulator.
module tb_pid_math;

  localparam int D_DEPTH = 12;
  localparam int D_GAIN  = 7;
`ifdef PID_ITERM_EN
  localparam bit ITERM_EN = 1'b1;
`else
  localparam bit ITERM_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               vld = 1'b0;
  logic signed [15:0] desired = '0;
  logic signed [15:0] actual = '0;
  logic               frz = 1'b0;
  logic               clr_i = 1'b0;
  logic signed [9:0]  pterm;
  logic signed [11:0] dterm;
  logic signed [11:0] iterm;
  logic               out_vld;

  int checks = 0;
  int errors = 0;
  int hist[$];
  int acc_m = 0;
  int exp_p = 0;
  int exp_d = 0;
  int exp_i = 0;

  pid_math dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld     (vld),
    .desired (desired),
    .actual  (actual),
    .frz     (frz),
    .clr_i   (clr_i),
    .pterm   (pterm),
    .dterm   (dterm),
    .iterm   (iterm),
    .out_vld (out_vld)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic check_output(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ov);
    check_output({tag, "_out_vld"}, out_vld, ov);
    check_output({tag, "_pterm"}, pterm, exp_p);
    check_output({tag, "_dterm"}, dterm, exp_d);
    check_output({tag, "_iterm"}, iterm, exp_i);
  endtask

  // One vld strobe; the model computes the expected terms from first principles
  task automatic apply_stimulus(input logic [15:0] des, input logic [15:0] act,
                                input logic f, input logic c, input bit gap);
    int e;
    e = clamp(int'($signed(act)) - int'($signed(des)), -512, 511);
    exp_p = (e >>> 1) + (e >>> 3);
    if (hist.size() >= D_DEPTH)
      exp_d = clamp(e - hist[D_DEPTH-1], -64, 63) * D_GAIN;
    else
      exp_d = 0;
    hist.push_front(e);
    if (hist.size() > D_DEPTH)
      void'(hist.pop_back());
    if (ITERM_EN) begin
      if (c)
        acc_m = 0;
      else if (!f)
        acc_m = clamp(acc_m + e, -131072, 131071);
      exp_i = acc_m >>> 6;
    end
    desired = des;
    actual  = act;
    frz     = f;
    clr_i   = c;
    vld     = 1'b1;
    @(posedge clk);
    #1;
    vld   = 1'b0;
    frz   = 1'b0;
    clr_i = 1'b0;
    check_all("strobe", 1'b1);
    if (gap) begin
      @(posedge clk);
      #1;
      check_all("hold", 1'b0);
    end
  endtask

  task automatic clear_only();
    clr_i = 1'b1;
    @(posedge clk);
    #1;
    clr_i = 1'b0;
    if (ITERM_EN)
      acc_m = 0;
    check_all("clr_novld", 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    hist.delete();
    acc_m = 0;
    exp_p = 0;
    exp_d = 0;
    exp_i = 0;
    check_all("reset", 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] a;

    $display("[TB] start, integrator %0s", ITERM_EN ? "enabled" : "disabled");
    do_reset();

    apply_stimulus(16'h0000, 16'h1000, 1'b0, 1'b0, 1'b1);
    check_output("p_pos_sat", pterm, 318);
    check_output("d_pos_warm", dterm, 0);
    apply_stimulus(16'h1000, 16'h0000, 1'b0, 1'b0, 1'b1);
    check_output("p_neg_sat", pterm, -320);

    do_reset();
    for (int i = 0; i < D_DEPTH; i++)
      apply_stimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    apply_stimulus(16'h0000, 16'd100, 1'b0, 1'b0, 1'b1);
    check_output("d_diff_sat", dterm, 441);

    do_reset();
    for (int i = 0; i < 4; i++)
      apply_stimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    apply_stimulus(16'h0000, 16'd100, 1'b0, 1'b0, 1'b1);
    check_output("d_fifth_vld", dterm, 0);

    do_reset();
    for (int i = 0; i < 8; i++)
      apply_stimulus(16'h0000, 16'd256, 1'b0, 1'b0, 1'b0);
    check_output("i_eight", iterm, ITERM_EN ? 32 : 0);
    for (int i = 0; i < 257; i++)
      apply_stimulus(16'h0000, 16'd511, 1'b0, 1'b0, 1'b0);
    check_output("i_pos_limit", iterm, ITERM_EN ? 2047 : 0);
    apply_stimulus(16'h0000, 16'd511, 1'b1, 1'b0, 1'b1);
    check_output("i_frz_hold", iterm, ITERM_EN ? 2047 : 0);
    apply_stimulus(16'h0000, 16'd511, 1'b1, 1'b1, 1'b0);
    check_output("i_clr_vld", iterm, 0);
    for (int i = 0; i < 300; i++)
      apply_stimulus(16'h1000, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_output("i_neg_limit", iterm, ITERM_EN ? -2048 : 0);
    clear_only();
    apply_stimulus(16'h0000, 16'd64, 1'b0, 1'b0, 1'b1);

    do_reset();
    for (int i = 0; i < 20; i++)
      apply_stimulus(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < D_DEPTH; i++) begin
      apply_stimulus(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
      check_output("d_rewarm", dterm, 0);
    end

    for (int i = 0; i < 400; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 2) != 0)
        a = d + 16'($urandom_range(0, 160)) - 16'd80;
      else
        a = 16'($urandom);
      apply_stimulus(d, a, ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
                     ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 49) == 0)
        clear_only();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pid_math.md
PID_MATH -- requirements
Module: pid_math

Interface
REQ-001 Parameter ERR_W, 10, signed width of the saturated error and of pterm.
REQ-002 Parameter D_DEPTH, 12, number of stages in the error delay queue used for the D term (1..32).
REQ-003 Parameter DDIFF_W, 7, signed width of the saturated D difference.
REQ-004 Parameter D_GAIN, 7, unsigned 5-bit constant multiplier for the D term.
REQ-005 Parameter I_ACC_W, 18, signed width of the integral accumulator.
REQ-006 Parameter I_SHIFT, 6, right-shift applied to the accumulator to form iterm.
REQ-007 Port clk  input  1  system clock, rising-edge.
REQ-008 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 Port vld  input  1  new inertial sample valid, single-cycle strobe.
REQ-010 Port desired  input  16  signed desired position.
REQ-011 Port actual  input  16  signed actual position.
REQ-012 Port frz  input  1  hold the integrator (anti-windup).
REQ-013 Port clr_i  input  1  synchronous clear of the integrator.
REQ-014 Port pterm  output  ERR_W  signed registered P term.
REQ-015 Port dterm  output  DDIFF_W+5  signed registered D term.
REQ-016 Port iterm  output  I_ACC_W-I_SHIFT  signed registered I term.
REQ-017 Port out_vld  output  1  one-cycle pulse marking updated terms.

Function
REQ-018 err SHALL be the 17-bit signed value actual-desired, saturated to ERR_W signed bits (err_sat).
REQ-019 The pterm SHALL be computed as (err_sat>>>1)+(err_sat>>>3).
REQ-020 On each vld, the delay queue SHALL shift, with stage 0 receiving err_sat; no shift occurs without vld.
REQ-021 D_diff SHALL be err_sat minus the last queue stage, saturated to DDIFF_W signed bits; the D product SHALL be D_diff_sat*D_GAIN (signed).
REQ-022 A fill counter SHALL count vld strobes, saturating at D_DEPTH; while count<D_DEPTH, the D product SHALL be forced to 0.
REQ-023 Integrator on vld: clr_i=1 -> 0; else frz=1 -> hold; else acc+sign-extended err_sat, saturating at +2^(I_ACC_W-1)-1 and -2^(I_ACC_W-1), with no wrap.
REQ-024 clr_i without vld SHALL also clear the accumulator; clr_i has priority over frz and over vld.
REQ-025 The pterm, dterm and iterm (acc>>>I_SHIFT, using the post-update accumulator) outputs SHALL register on the clock edge at which vld is sampled; out_vld SHALL be high for exactly the following cycle; latency SHALL be 1 clk.
REQ-026 The outputs SHALL hold their value between vld strobes; back-to-back vld SHALL update on every cycle.

Reset
REQ-027 On rst_n low, the following SHALL clear asynchronously to 0: pterm, dterm, iterm, out_vld, all queue stages, the fill counter and the accumulator.
REQ-028 Reset mid-operation SHALL restart warm-up; dterm remains 0 until D_DEPTH new samples have been captured.

Configuration
REQ-029 With macro PID_ITERM_EN defined, the integrator SHALL be built per REQ-023/024.
REQ-030 Without PID_ITERM_EN, the accumulator SHALL be absent, iterm SHALL be tied to 0, and frz/clr_i SHALL be ignored; P/D behaviour SHALL be unchanged.

Verification (defaults)
REQ-031 actual=0x1000, desired=0, one vld -> next cycle: pterm=318 (err_sat=511), dterm=0, out_vld=1 for one cycle.
REQ-032 actual=0, desired=0x1000, vld -> pterm=-320 (err_sat=-512).
REQ-033 Twelve vld with err=0, then vld with err=100 -> dterm=441 (D_diff sat 63); the same final sample sent as only the 5th vld after reset -> dterm=0.
REQ-034 PID_ITERM_EN: 8 vld with err=256 -> iterm=32; then 257 further vld with err=511 -> iterm=2047 with no wrap; vld with frz=1 -> iterm unchanged; clr_i=1 with vld -> iterm=0.
REQ-035 rst_n low for 1 cycle after 20 samples -> all outputs 0 immediately; the next 12 vld give dterm=0.
REQ-036 PID_ITERM_EN undefined: stimulus of REQ-034 -> iterm=0 throughout; pterm/dterm match REQ-031/033.
